// File: rtl/capi_tag_credit_tracker_pkg.sv
// Shared types for the CAPI tag/credit tracker: FSM states and error bit positions
// used by both the RTL and the MMIO error report.
package capi_tag_credit_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tracker_state_t;

  localparam int ERR_W            = 5;
  localparam int ERR_DUP_TAG      = 0;
  localparam int ERR_ORPHAN_RSP   = 1;
  localparam int ERR_CREDIT_UNDER = 2;
  localparam int ERR_CREDIT_OVER  = 3;
  localparam int ERR_TIMEOUT      = 4;

  localparam int CROOM_W = 8;

endpackage

// File: rtl/capi_tag_credit_tracker_tag_bitmap.sv
// In-flight tag set: one bit per tag, pre-update read ports for both the issue and
// response tags, and a running population count.
module tag_bitmap #(
  parameter int TAG_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             set_en_i,
  input  logic [TAG_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [TAG_W-1:0] clr_idx_i,
  output logic             set_bit_o,
  output logic             clr_bit_o,
  output logic [TAG_W:0]   count_o
);

  localparam int DEPTH = 2 ** TAG_W;

  logic [DEPTH-1:0] bits_q, bits_d;
  logic [TAG_W:0]   count_q, count_d;

  assign set_bit_o = bits_q[set_idx_i];
  assign clr_bit_o = bits_q[clr_idx_i];
  assign count_o   = count_q;

  // Clear before set so a same-tag retire/reissue leaves the bit set.
  always_comb begin
    bits_d = bits_q;
    if (clr_en_i) bits_d[clr_idx_i] = 1'b0;
    if (set_en_i) bits_d[set_idx_i] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({set_en_i, clr_en_i})
      2'b10:   count_d = count_q + (TAG_W+1)'(1);
      2'b01:   count_d = count_q - (TAG_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/capi_tag_credit_tracker.sv
// PSL command credit and in-flight tag tracker with sticky protocol error flags,
// response watchdog and a drain handshake for clean software resets.
module capi_tag_credit_tracker
  import capi_tag_credit_tracker_pkg::*;
#(
  parameter int TAG_W          = 8,
  parameter int CREDIT_W       = 9,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                job_start_i,
  input  logic [CROOM_W-1:0]  croom_in_i,
  input  logic                drain_req_i,
  input  logic                cmd_valid_i,
  input  logic [TAG_W-1:0]    cmd_tag_i,
  input  logic                rsp_valid_i,
  input  logic [TAG_W-1:0]    rsp_tag_i,
  input  logic [CREDIT_W-1:0] rsp_credits_i,
  input  logic                err_clear_i,
  output logic                cmd_ready_o,
  output logic [CREDIT_W-1:0] credits_o,
  output logic [TAG_W:0]      outstanding_o,
  output logic                idle_o,
  output logic                drain_done_o,
  output logic [ERR_W-1:0]    error_flags_o
);

  localparam int CW1  = CREDIT_W + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  tracker_state_t state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [CROOM_W-1:0]  croom_q, croom_d;
  logic [ERR_W-1:0]    err_q, err_d, err_new;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                drain_done_q, drain_done_d;

  logic [TAG_W:0] outstanding;
  logic           cmd_bit, rsp_bit;
  logic           cmd_ready, issue, rsp_clr, dup, cmd_set;
  logic           over, under_c;

  logic signed [CW1-1:0] base_s, dec_s, rsp_s, sum_s, limit_s;

  assign cmd_ready = (state_q == ST_RUN) && (credits_q != '0);
  assign issue     = cmd_valid_i & cmd_ready;
  assign rsp_clr   = rsp_valid_i & rsp_bit;
  // A bit retired by a same-cycle response on the same tag is free to reuse.
  assign dup       = issue & cmd_bit & ~(rsp_clr & (cmd_tag_i == rsp_tag_i));
  assign cmd_set   = issue & ~dup;

  tag_bitmap #(.TAG_W(TAG_W)) u_bitmap (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .set_en_i  (cmd_set),
    .set_idx_i (cmd_tag_i),
    .clr_en_i  (rsp_clr),
    .clr_idx_i (rsp_tag_i),
    .set_bit_o (cmd_bit),
    .clr_bit_o (rsp_bit),
    .count_o   (outstanding)
  );

  // A job_start reload replaces the running count; returned credits that cycle are dropped.
  always_comb begin
    croom_d = job_start_i ? croom_in_i : croom_q;
    limit_s = {{(CW1-CROOM_W){1'b0}}, croom_d};
    base_s  = job_start_i ? limit_s : {1'b0, credits_q};
    dec_s   = issue ? CW1'(1) : '0;
    rsp_s   = (rsp_valid_i && !job_start_i) ? {rsp_credits_i[CREDIT_W-1], rsp_credits_i} : '0;
    sum_s   = base_s - dec_s + rsp_s;

    credits_d = sum_s[CREDIT_W-1:0];
    over      = 1'b0;
    under_c   = 1'b0;
    if (sum_s > limit_s) begin
      over      = 1'b1;
      credits_d = limit_s[CREDIT_W-1:0];
    end else if (sum_s[CW1-1]) begin
      under_c   = 1'b1;
      credits_d = '0;
    end
  end

  always_comb begin
    if (rsp_valid_i || outstanding == '0) wd_d = '0;
    else if (wd_q != WD_MAX)              wd_d = wd_q + WD_W'(1);
    else                                  wd_d = wd_q;
  end

  always_comb begin
    err_new                   = '0;
    err_new[ERR_DUP_TAG]      = dup;
    err_new[ERR_ORPHAN_RSP]   = rsp_valid_i & ~rsp_bit;
    err_new[ERR_CREDIT_UNDER] = (cmd_valid_i & ~cmd_ready) | under_c;
    err_new[ERR_CREDIT_OVER]  = over;
    err_new[ERR_TIMEOUT]      = (wd_q == WD_MAX);
    err_d = (err_clear_i ? '0 : err_q) | err_new;
  end

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (job_start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (job_start_i)      state_d = ST_RUN;
        else if (drain_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (job_start_i) begin
          state_d = ST_RUN;
        end else if (outstanding == '0 && !rsp_valid_i) begin
          state_d      = ST_IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      credits_q    <= '0;
      croom_q      <= '0;
      err_q        <= '0;
      wd_q         <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      croom_q      <= croom_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign cmd_ready_o   = cmd_ready;
  assign credits_o     = credits_q;
  assign outstanding_o = outstanding;
  assign idle_o        = (state_q == ST_IDLE) && (outstanding == '0);
  assign drain_done_o  = drain_done_q;
  assign error_flags_o = err_q;

endmodule

// File: doc/capi_tag_credit_tracker.md
# capi_tag_credit_tracker

Sits between `cached_afu` command/response ports and the PSL. Tracks PSL command credits from job start, and the set of in-flight command tags. Gates command issue on available credit, detects protocol violations (duplicate tag, orphan response, credit over/underflow, response timeout), and supports a drain handshake so software resets land only when nothing is outstanding.

## Interface
Parameters:
- `TAG_W`, 8 — PSL command tag width; tag space is 2^TAG_W entries.
- `CREDIT_W`, 9 — credit counter width; signed response-credit width.
- `TIMEOUT_CYCLES`, 4096 — response watchdog limit; must be ≥ 2.

Ports:
- `clock` in 1 — the single clock.
- `reset` in 1 — asynchronous, active-high.
- `job_start` in 1 — pulse; loads `croom_in` as the initial credit.
- `croom_in` in 8 — PSL croom value (max credits).
- `drain_req` in 1 — level; stop issuing and wait for all tags to retire.
- `cmd_valid` in 1 — command issued this cycle.
- `cmd_tag` in `TAG_W` — tag of the issued command.
- `rsp_valid` in 1 — PSL response this cycle.
- `rsp_tag` in `TAG_W` — tag of the response.
- `rsp_credits` in `CREDIT_W` — signed credits returned.
- `err_clear` in 1 — pulse; clears sticky errors.
- `cmd_ready` out 1 — issue permitted.
- `credits` out `CREDIT_W` — current credit count.
- `outstanding` out `TAG_W+1` — number of tags in flight.
- `idle` out 1 — state IDLE and `outstanding`==0.
- `drain_done` out 1 — drain completed.
- `error_flags` out 5 — sticky errors: [0] dup_tag, [1] orphan_rsp, [2] credit_underflow, [3] credit_overflow, [4] timeout.

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE→RUN on `job_start`.
  - RUN→DRAIN on `drain_req`.
  - DRAIN→IDLE when `outstanding`==0 and no `rsp_valid` that cycle; `drain_done` pulses one cycle on that transition.
  - `job_start` in RUN or DRAIN reloads credits and stays in or enters RUN.
- `cmd_ready` = (state==RUN) & (`credits` > 0). It is combinational from registers, not from `cmd_valid`.
- Tag bitmap of 2^TAG_W bits:
  - On issue, set bit `cmd_tag`.
  - On response, clear bit `rsp_tag`.
- Same cycle with `cmd_tag` == `rsp_tag`: clear first, then set. The bit ends set; no error, provided the tag was outstanding.
- Credit update per cycle: next = credits − (issue ? 1 : 0) + (rsp_valid ? rsp_credits : 0). Computed at `CREDIT_W+1` bits signed.
  - Result > croom: flag credit_overflow, saturate at croom.
  - Result < 0: flag credit_underflow, clamp to 0.
- `cmd_valid` while `cmd_ready`==0: flag credit_underflow. Bitmap and credits unchanged.
- `cmd_valid` with the tag bit already set (and not cleared same cycle): flag dup_tag. Bitmap unchanged; credit still decremented.
- `rsp_valid` with the tag bit clear: flag orphan_rsp. Bitmap unchanged; credits still applied.
- `outstanding` increments/decrements in step with accepted bitmap set/clear. Simultaneous accepted set and clear leaves it unchanged.
- Watchdog counter:
  - Resets to 0 on any `rsp_valid` or when `outstanding`==0.
  - Otherwise increments.
  - Reaching `TIMEOUT_CYCLES`−1 sets the timeout flag; the counter holds.
- Errors are sticky until `err_clear`. An error detected in the same cycle as `err_clear` wins (flag stays set).

## Timing
- Reset values: state IDLE, `credits` 0, `outstanding` 0, bitmap 0, `cmd_ready` 0, `idle` 1, `drain_done` 0, `error_flags` 0, watchdog 0.
- All state updates take effect the cycle after the input; `cmd_ready` reflects them in that same next cycle.
- Latency from issue to credit visible: 1 cycle. From `job_start` to `cmd_ready`: 1 cycle when `croom_in` > 0.
- Reset mid-operation clears everything asynchronously; in-flight tags are forgotten.
- `job_start` and `cmd_valid` in the same cycle: the load wins (credits = croom_in − 1 if the issue was legal under the old `cmd_ready`).

## Structure
- Shared package gets the `tracker_state_t` enum (IDLE/RUN/DRAIN) and the error-bit index constants, so the MMIO error report stays consistent.
- One sub-module: `tag_bitmap`. It holds the 2^TAG_W set/clear array, returns the pre-update bit for both ports, and keeps the population count.

## Test plan
- Basic flow: croom=4, `job_start`, issue tags 1,2,3,4 → `cmd_ready`=0 and `outstanding`=4. Then responses for tags 1..4 with credits=1 each → credits=4, `outstanding`=0.
- Duplicate tag: issue tag 7 twice without a response → error_flags[0]=1. Then `err_clear` → flags 0.
- Orphan response: response for tag 9 that was never issued → error_flags[1]=1; credits +1, saturating at croom.
- Overflow and simultaneity: croom=2, issue and respond on tag 5 in the same cycle with credits=3 → credit_overflow set, credits=2, bit 5 set.
- Timeout: TIMEOUT_CYCLES=16, issue one tag, no response → error_flags[4] set at cycle 16; a response earlier than that prevents it.
- Drain and reset: `drain_req` with 2 outstanding → `cmd_ready`=0; two responses → `drain_done` pulse, state IDLE. Then assert `reset` mid-RUN → all outputs return to reset values immediately.
